// File: rtl/redmule_castout_packer.sv
// redmule_castout_packer: output-cast stage between the Z-buffer drain and the
// streamer sink. Casts FP16 lanes to FP8 (E5M2, round-to-nearest-even) and packs
// two half-width cast results into one dense beat, or passes beats through.
module redmule_castout_packer #(
  parameter int unsigned DW      = 256,
  parameter int unsigned LANE_W  = 16,
  parameter int unsigned N_LANES = DW / LANE_W
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            cast_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [DW-1:0]   in_data_i,
  input  logic            in_last_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [DW-1:0]   out_data_o,
  output logic [DW/8-1:0] out_strb_o,
  output logic            out_last_o
);

  localparam int unsigned HW  = DW / 2;   // width of one packed cast vector
  localparam int unsigned SW  = DW / 8;   // strobe width
  localparam int unsigned HSW = DW / 16;  // strobe bits covering one half

  typedef enum logic {EMPTY, HALF} state_e;

  state_e            state_reg, state_next;
  logic [HW-1:0]     half_reg, half_next;
  logic              out_valid_reg, out_valid_next;
  logic [DW-1:0]     out_data_reg, out_data_next;
  logic [SW-1:0]     out_strb_reg, out_strb_next;
  logic              out_last_reg, out_last_next;
  logic [HW-1:0]     cast_vec;
  logic              out_free;
  logic              flush_stall;
  logic              accept;

  // FP16 -> FP8 E5M2: truncate to {e, m[9:8]} and round to nearest even. The
  // rounding carry ripples into the exponent, so 30/max rounds up to Inf.
  function automatic logic [7:0] cast_lane(input logic [15:0] x);
    logic       rnd;
    logic [6:0] mag;
    rnd = x[7] & ((|x[6:0]) | x[8]);
    mag = x[14:8] + {6'b0, rnd};
    if (x[14:10] == 5'h1F && x[9:0] != 10'h0)
      return {x[15], 7'h7E};  // canonical quiet NaN, sign kept
    return {x[15], mag};
  endfunction

  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
    assign cast_vec[gi*8 +: 8] = cast_lane(in_data_i[gi*LANE_W +: LANE_W]);
  end

  // A passthrough beat cannot follow a pending half directly: the half is
  // flushed on its own first, and the passthrough beat waits.
  assign out_free    = ~out_valid_reg | out_ready_i;
  assign flush_stall = (state_reg == HALF) & in_valid_i & ~cast_i;
  assign in_ready_o  = ~clear_i & out_free & ~flush_stall;
  assign accept      = in_valid_i & in_ready_o;

  // Next-state: pack FSM, half register and output register load/drain.
  always_comb begin
    state_next     = state_reg;
    half_next      = half_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_strb_next  = out_strb_reg;
    out_last_next  = out_last_reg;
    if (clear_i) begin
      state_next     = EMPTY;
      half_next      = '0;
      out_valid_next = 1'b0;
      out_data_next  = '0;
      out_strb_next  = '0;
      out_last_next  = 1'b0;
    end else begin
      if (out_valid_reg && out_ready_i)
        out_valid_next = 1'b0;
      if (flush_stall && out_free) begin
        out_valid_next = 1'b1;
        out_data_next  = {{HW{1'b0}}, half_reg};
        out_strb_next  = {{HSW{1'b0}}, {HSW{1'b1}}};
        out_last_next  = 1'b0;
        state_next     = EMPTY;
      end else if (accept) begin
        if (!cast_i) begin
          out_valid_next = 1'b1;
          out_data_next  = in_data_i;
          out_strb_next  = '1;
          out_last_next  = in_last_i;
        end else if (state_reg == HALF) begin
          out_valid_next = 1'b1;
          out_data_next  = {cast_vec, half_reg};
          out_strb_next  = '1;
          out_last_next  = in_last_i;
          state_next     = EMPTY;
        end else if (in_last_i) begin
          out_valid_next = 1'b1;
          out_data_next  = {{HW{1'b0}}, cast_vec};
          out_strb_next  = {{HSW{1'b0}}, {HSW{1'b1}}};
          out_last_next  = 1'b1;
        end else begin
          half_next  = cast_vec;
          state_next = HALF;
        end
      end
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= EMPTY;
      half_reg      <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_strb_reg  <= '0;
      out_last_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      half_reg      <= half_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_strb_reg  <= out_strb_next;
      out_last_reg  <= out_last_next;
    end
  end

  assign out_valid_o = out_valid_reg;
  assign out_data_o  = out_data_reg;
  assign out_strb_o  = out_strb_reg;
  assign out_last_o  = out_last_reg;

endmodule

// File: doc/redmule_castout_packer.md
Name: redmule_castout_packer

Overview:
- Streaming output-cast stage between the RedMulE Z-buffer drain and the streamer sink.
- Casts each FP16 lane of an incoming beat to FP8 (E5M2) with round-to-nearest-even, or passes beats through unchanged.
- In cast mode, two half-width results are packed into one dense output beat, halving memory traffic.
- Pipelined with valid/ready handshakes on both sides. Supports partial (odd-count) flush on last beat and synchronous clear.

Parameters:
- DW, 256, data width of input and output beats in bits; multiple of 32.
- LANE_W, 16, source lane width (FP16); fixed, present for clarity; DW % LANE_W == 0.
- N_LANES, DW/LANE_W, derived number of cast lanes per beat.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous clear; drops pending half-word and output register
- cast_i  in  1  1 = FP16->FP8 cast + pack, 0 = passthrough; sampled with each accepted beat
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  input beat accepted when in_valid_i & in_ready_o
- in_data_i  in  DW  input beat; lane i = in_data_i[16i +: 16]
- in_last_i  in  1  final beat of stream
- out_valid_o  out  1  output beat valid
- out_ready_i  in  1  downstream ready
- out_data_o  out  DW  output beat
- out_strb_o  out  DW/8  byte enables of out_data_o
- out_last_o  out  1  final output beat of stream

Behaviour:
- Reset and clear: out_valid_o=0, out_data_o=0, out_strb_o=0, out_last_o=0; pack state EMPTY; half register = 0. clear_i takes priority over any handshake in the same cycle.
- Output register:
  - Single stage. Loaded when a beat completes; out_valid_o rises the next cycle.
  - Holds value until out_valid_o & out_ready_i.
  - in_ready_o = ~clear_i & (~out_valid_o | out_ready_i), except the HALF-mode-switch stall below.
- Lane cast (combinational), FP16 {s, e[4:0], m[9:0]} -> FP8 {s, e, m8[1:0]}:
  - NaN (e=31, m≠0): output {s, 5'h1F, 2'b10}.
  - Otherwise: base = {e, m[9:8]}; lsb=m[8], g=m[7], st=|m[6:0]; round up if g & (st | lsb).
  - Rounding carry propagates into the exponent; exponent reaching 31 yields ±Inf (mantissa 00). Inf inputs stay Inf.
- Pack FSM, states EMPTY and HALF:
  - EMPTY, cast beat, ~last: store the N_LANES-byte cast vector in the low half register; go to HALF; no output.
  - EMPTY, cast beat, last: output {zeros, cast}; strb low DW/16 bytes set; out_last_o=1; stay EMPTY.
  - HALF, cast beat: output {cast(beat), half}; strb all ones; out_last_o=in_last_i; go to EMPTY.
  - EMPTY, passthrough beat: output in_data_i unchanged; strb all ones; out_last_o=in_last_i.
  - HALF, passthrough beat pending:
    - in_ready_o held 0.
    - When the output register is free, emit {zeros, half} with low-half strb and out_last_o=0; go to EMPTY.
    - The passthrough beat is accepted on a later cycle.
- Latency: 1 cycle from the accepting handshake of the completing beat to out_valid_o. Full throughput: one input beat per cycle when out_ready_i is held high.
- Backpressure: output fields stable while out_valid_o & ~out_ready_i. in_data_i is not required to be stable before acceptance.
- Reset mid-operation: asynchronous; pending half is lost; all outputs return to reset values immediately.

Test Plan:
- DW=32; cast beats 0x3D80_3C00 then 0xBC00_7BFF (last=1) -> one output 0xBC7C_3E3C, strb 4'hF, last=1, one cycle after the second accept.
- DW=32; cast beat 0x3C80_0000 (last=1), tie-to-even -> output 0x0000_3C00, strb 4'h3, last=1.
- DW=32; cast beat 0x7E01_FC00 (NaN, -Inf), last=1 -> output 0x0000_7EFC, strb 4'h3.
- DW=32; passthrough 0xDEAD_BEEF while out_ready_i low for 3 cycles -> output held stable at 0xDEAD_BEEF with strb 4'hF; in_ready_o=0 during the stall; one transfer when ready rises.
- DW=32; cast beat 0x3C00_3C00 (no last), then passthrough 0x1234_5678 -> first output 0x0000_3C3C strb 4'h3 last=0, then 0x1234_5678 strb 4'hF.
- Cast beat into HALF, then clear_i pulse, then cast beat 0x3C00_3C00 with last=1 -> single output 0x0000_3C3C, strb 4'h3; no stale half emitted.
